hack_alu_ctrl: RTL and testbench

Multi-cycle control and register unit that drives the 8-bit Hack ALU. It accepts 16-bit Hack instructions over a valid/ready handshake and holds the A, D and PC registers. For each C-instruction it reads M from memory when required, drives the ALU's six control bits and operands, writes back the result and evaluates the jump condition from the ALU's `zr`/`ng` flags.

---
 rtl/hack_alu_ctrl.sv | 142 ++++++++++++++
 tb/tb_hack_alu_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_ctrl.sv
// Multi-cycle control/register unit for the 8-bit Hack ALU: holds A, D and PC,
// fetches M when needed, drives ALU controls and resolves writeback and jumps.
module hack_alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [7:0]  alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  pc,
  output logic [7:0]  a_reg,
  output logic [7:0]  d_reg
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_MEMRD = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  a_r, a_s;
  logic [7:0]  d_r, d_s;
  logic [7:0]  pc_r, pc_s;
  logic [15:0] ir_r, ir_s;
  logic [7:0]  m_r, m_s;
  logic        jump_s;
  logic        unused_ir_bits_s;

  // Opcode bits 15:13 are only meaningful at fetch time.
  assign unused_ir_bits_s = ^ir_r[15:13];

  assign jump_s = (ir_r[2] & alu_ng) |
                  (ir_r[1] & alu_zr) |
                  (ir_r[0] & ~alu_ng & ~alu_zr);

  // State register and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      a_r     <= 8'h00;
      d_r     <= 8'h00;
      pc_r    <= 8'h00;
      ir_r    <= 16'h0000;
      m_r     <= 8'h00;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      d_r     <= d_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      m_r     <= m_s;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    d_s     = d_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    m_s     = m_r;
    case (state_r)
      ST_FETCH: begin
        if (instr_valid) begin
          if (!instr[15]) begin
            a_s     = instr[7:0];
            pc_s    = pc_r + 8'd1;
            state_s = ST_FETCH;
          end else begin
            ir_s    = instr;
            state_s = instr[12] ? ST_MEMRD : ST_EXEC;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_MEMRD: begin
        if (mem_rvalid) begin
          m_s     = mem_rdata;
          state_s = ST_EXEC;
        end else begin
          state_s = ST_MEMRD;
        end
      end
      ST_EXEC: begin
        // Jump target and write address both use the pre-update A.
        if (ir_r[5]) begin
          a_s = alu_out;
        end else begin
          a_s = a_r;
        end
        if (ir_r[4]) begin
          d_s = alu_out;
        end else begin
          d_s = d_r;
        end
        if (jump_s) begin
          pc_s = a_r;
        end else begin
          pc_s = pc_r + 8'd1;
        end
        state_s = ST_FETCH;
      end
      default: begin
        state_s = ST_FETCH;
      end
    endcase
  end

  // Outputs decode directly from registered state
  assign instr_ready = (state_r == ST_FETCH);
  assign mem_rd      = (state_r == ST_MEMRD);
  assign mem_wr      = (state_r == ST_EXEC) & ir_r[3];
  assign {zx, nx, zy, ny, f, no} = (state_r == ST_EXEC) ? ir_r[11:6] : 6'b000000;

  assign alu_x     = d_r;
  assign alu_y     = ir_r[12] ? m_r : a_r;
  assign mem_addr  = a_r;
  assign mem_wdata = alu_out;
  assign pc        = pc_r;
  assign a_reg     = a_r;
  assign d_reg     = d_r;

endmodule

// File: tb/tb_hack_alu_ctrl.sv
// Directed bench for hack_alu_ctrl with an ALU/memory model and a write scoreboard.
module tb_hack_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no;
  logic        alu_zr, alu_ng;
  logic [7:0]  mem_addr, mem_rdata, mem_wdata;
  logic        mem_rd, mem_rvalid, mem_wr;
  logic [7:0]  pc, a_reg, d_reg;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem [256];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  exp_a = 8'h00;
  logic [7:0]  exp_pc = 8'h00;
  int          busy, rd_cycles;
  logic [5:0]  last_ctrl;

  hack_alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
  );

  always #5 clk = ~clk;

  // Reference Hack ALU
  logic [7:0] x1, x2, y1, y2, o1;
  always_comb begin
    x1 = zx ? 8'h00 : alu_x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? 8'h00 : alu_y;
    y2 = ny ? ~y1 : y1;
    o1 = f ? (x2 + y2) : (x2 & y2);
    alu_out = no ? ~o1 : o1;
  end
  assign alu_zr = (alu_out == 8'h00);
  assign alu_ng = alu_out[7];

  // Memory with programmable read latency
  assign mem_rdata  = mem[mem_addr];
  assign mem_rvalid = mem_rd && (wait_cnt >= wait_cfg);
  always @(posedge clk) begin
    if (mem_rd && !mem_rvalid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each write strobe against the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_wr) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 16'hxxxx);
      end else begin
        chk("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
      end
    end
  end

  task automatic exec(input logic [15:0] w, input logic taken);
    int guard;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    busy = 0; rd_cycles = 0; last_ctrl = 6'b000000;
    @(negedge clk);
    while (!instr_ready && guard < 50) begin
      if (mem_rd) rd_cycles++;
      else last_ctrl = {zx, nx, zy, ny, f, no};
      busy++;
      @(negedge clk);
      guard++;
    end
    chk("no_timeout", {15'd0, guard < 50}, 16'd1);
    if (!w[15]) begin
      exp_a = w[7:0];
      exp_pc = exp_pc + 8'd1;
    end else begin
      exp_pc = taken ? exp_a : exp_pc + 8'd1;
    end
    chk("pc", {8'h00, pc}, {8'h00, exp_pc});
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_rd_wr", {14'd0, mem_rd, mem_wr}, 16'd0);
    chk("rst_ctrl", {10'd0, zx, nx, zy, ny, f, no}, 16'd0);
    chk("rst_regs", {a_reg, d_reg}, 16'h0000);
    chk("rst_pc", {8'h00, pc}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // A-instruction then D=A
    exec(16'h0005, 1'b0);
    chk("a_instr_busy", busy[15:0], 16'd0);
    chk("a_after_ainstr", {8'h00, a_reg}, 16'h0005);
    exec(16'hEC10, 1'b0);
    chk("d_eq_a_busy", busy[15:0], 16'd1);
    chk("d_eq_a_ctrl", {10'd0, last_ctrl}, 16'b110000);
    chk("d_eq_a_regs", {a_reg, d_reg}, 16'h0505);

    // Read M with two wait cycles, AMD=M+1
    exec(16'h0010, 1'b0);
    mem[8'h10] = 8'h7F;
    wait_cfg = 2;
    wr_q.push_back({8'h10, 8'h80});
    exec(16'hFDF8, 1'b0);
    exp_a = 8'h80;
    chk("amd_rd_cycles", rd_cycles[15:0], 16'd3);
    chk("amd_busy", busy[15:0], 16'd4);
    chk("amd_regs", {a_reg, d_reg}, 16'h8080);
    wait_cfg = 0;

    // Conditional jump JEQ, taken then not taken
    exec(16'hEA90, 1'b0);          // D=0
    exec(16'h0020, 1'b0);
    exec(16'hE302, 1'b1);          // D;JEQ
    exec(16'hEFD0, 1'b0);          // D=1
    exec(16'h0020, 1'b0);
    exec(16'hE302, 1'b0);
    chk("d_is_one", {8'h00, d_reg}, 16'h0001);

    // JGT taken with D=1, JLT not taken with D=1
    exec(16'hE301, 1'b1);
    exec(16'hE304, 1'b0);

    // Negative and unconditional jumps
    exec(16'hEE90, 1'b0);          // D=-1
    chk("d_is_ff", {8'h00, d_reg}, 16'h00FF);
    exec(16'hE304, 1'b1);          // D;JLT
    exec(16'hEA90, 1'b0);          // D=0
    exec(16'hEA87, 1'b1);          // 0;JMP

    // AM=D+1;JMP: write address and jump target use the old A
    exec(16'hEFD0, 1'b0);          // D=1
    wr_q.push_back({8'h20, 8'h02});
    exec(16'hE7EF, 1'b1);
    exp_a = 8'h02;
    chk("am_new_a", {8'h00, a_reg}, 16'h0002);

    // Reset while waiting for read data
    wait_cfg = 8;
    @(negedge clk);
    instr = 16'hFC10;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("memrd_active", {14'd0, mem_rd, instr_ready}, 16'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd", {14'd0, mem_rd, mem_wr}, 16'd0);
    chk("rst_mid_regs", {a_reg, d_reg}, 16'h0000);
    chk("rst_mid_pc", {8'h00, pc}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = 8'h00;
    exp_pc = 8'h00;
    wait_cfg = 0;
    @(negedge clk);
    chk("post_rst_ready", {14'd0, instr_ready, mem_rd}, 16'b10);

    // PC wrap with back-to-back A-instructions
    instr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      instr = {8'h00, i[7:0]};
      if (i == 128) begin
        chk("wrap_mid_pc", {8'h00, pc}, 16'h0080);
        chk("wrap_ready", {15'd0, instr_ready}, 16'd1);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("wrap_pc", {8'h00, pc}, 16'h0000);
    chk("wrap_a", {8'h00, a_reg}, 16'h00FF);

    @(negedge clk);
    chk("writes_drained", wr_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
